// File: rtl/mc_fork_buf.sv
// Store-and-forward packet buffer with multicast fork: holds one packet, feeds head
// fields to the route decoder, then replays it once or twice (absorb-and-forward).
module mc_fork_buf #(
    parameter int         DATAW      = 64,
    parameter int         DEPTH      = 4,
    parameter logic [2:0] LOCAL_PORT = 3'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_head,
    input  logic             in_tail,
    output logic             hdr_um_type,
    output logic [4:0]       hdr_addr0,
    output logic [19:0]      hdr_addr1,
    input  logic [2:0]       dec_port,
    input  logic [19:0]      dec_addr1_rm,
    input  logic             dec_fwdab_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_head,
    output logic             out_tail,
    output logic [2:0]       out_port,
    output logic             err_len
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_ROUTE  = 3'd2;
    localparam logic [2:0] S_SEND_A = 3'd3;
    localparam logic [2:0] S_SEND_B = 3'd4;

    logic [2:0]       state;
    logic [DATAW-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [2:0]       rt_port;
    logic [19:0]      rt_addr1_rm;
    logic             rt_fwdab;
    logic             in_fire;
    logic             out_fire;
    logic             sending;
    logic             last_slot;
    logic             store_en;

    // Second-pass head carries the decoder's pruned multicast bitmap in [24:5].
    function automatic logic [DATAW-1:0] rewrite_addr1(input logic [DATAW-1:0] flit,
                                                       input logic [19:0]      bitmap);
        logic [DATAW-1:0] r;
        r       = flit;
        r[24:5] = bitmap;
        return r;
    endfunction

    assign sending   = (state == S_SEND_A) || (state == S_SEND_B);
    assign in_ready  = !rst && ((state == S_IDLE) || (state == S_FILL));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = sending;
    assign out_fire  = out_valid && out_ready;
    assign last_slot = ({1'b0, rd_ptr} == (cnt - CW'(1)));
    assign out_head  = sending && (rd_ptr == '0);
    assign out_tail  = sending && last_slot;
    assign store_en  = in_fire && (((state == S_IDLE) && in_head) || (state == S_FILL));
    assign wr_idx    = (state == S_IDLE) ? '0 : cnt[AW-1:0];

    always_comb begin
        out_port = 3'd0;
        if (state == S_SEND_A)
            out_port = rt_fwdab ? LOCAL_PORT : rt_port;
        else if (state == S_SEND_B)
            out_port = rt_port;
    end

    always_comb begin
        out_data = mem[rd_ptr];
        if ((state == S_SEND_B) && (rd_ptr == '0))
            out_data = rewrite_addr1(mem[rd_ptr], rt_addr1_rm);
    end

    // Flit storage: not reset, validity is tracked by cnt.
    always_ff @(posedge clk) begin
        if (store_en)
            mem[wr_idx] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rd_ptr      <= '0;
            rt_port     <= 3'd0;
            rt_addr1_rm <= 20'd0;
            rt_fwdab    <= 1'b0;
            hdr_um_type <= 1'b0;
            hdr_addr0   <= 5'd0;
            hdr_addr1   <= 20'd0;
            err_len     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire && in_head) begin
                        hdr_um_type <= in_data[DATAW-1];
                        hdr_addr1   <= in_data[24:5];
                        hdr_addr0   <= in_data[4:0];
                        cnt         <= CW'(1);
                        state       <= in_tail ? S_ROUTE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_fire) begin
                        cnt <= cnt + CW'(1);
                        if (in_tail) begin
                            state <= S_ROUTE;
                        end else if (cnt == CW'(DEPTH - 1)) begin
                            // Truncate: the last slot becomes the tail, the rest is dropped in IDLE.
                            err_len <= 1'b1;
                            state   <= S_ROUTE;
                        end
                    end
                end
                S_ROUTE: begin
                    rt_port     <= dec_port;
                    rt_addr1_rm <= dec_addr1_rm;
                    rt_fwdab    <= dec_fwdab_en;
                    rd_ptr      <= '0;
                    state       <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (out_fire) begin
                        if (last_slot) begin
                            rd_ptr <= '0;
                            state  <= rt_fwdab ? S_SEND_B : S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                S_SEND_B: begin
                    if (out_fire) begin
                        if (last_slot) begin
                            rd_ptr <= '0;
                            state  <= S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mc_fork_buf.md
# mc_fork_buf

Per-input-port packet buffer and multicast fork stage, sitting directly upstream of the router's `dec_rt` route decoder and downstream of the link receiver. It stores one packet (store-and-forward), presents the head-flit routing fields to the decoder, and latches the decoder's port/`addr1_rm`/`fwdab_en` result. It then replays the packet toward the switch: once for unicast, multicast-forward or final absorb; twice for absorb-and-forward (local copy first, then forwarded copy with rewritten multicast bitmap).

## Interface
- `DATAW`, 64: flit width. Head flit layout: bit 63 `um_type`, [24:5] `addr1` (20-bit one-hot node bitmap), [4:0] `addr0`.
- `DEPTH`, 4: maximum flits per packet; power of two.
- `LOCAL_PORT`, 3'd4: port code of the local ejection port, used for the first pass of absorb-and-forward.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid` / `in_ready`  in / out  1  upstream flit handshake.
- `in_data`  in  DATAW  flit. `in_head`, `in_tail`  in  1  head/tail markers; head and tail may be the same flit.
- `hdr_um_type`, `hdr_addr0`, `hdr_addr1`  out  1 / 5 / 20  registered head fields driving the decoder.
- `dec_port`, `dec_addr1_rm`, `dec_fwdab_en`  in  3 / 20 / 1  decoder results.
- `out_valid` / `out_ready`  out / in  1  downstream (switch) handshake.
- `out_data`  out  DATAW. `out_head`, `out_tail`  out  1. `out_port`  out  3  destination port for the current pass.
- `err_len`  out  1  sticky: a packet exceeded DEPTH flits.

## Operation
- States: IDLE, FILL, ROUTE, SEND_A, SEND_B.
- IDLE: `in_ready`=1. An accepted head flit is written to slot 0, its fields are loaded into the `hdr_*` registers, and the write count becomes 1.
  - If the head flit is also the tail, go to ROUTE; otherwise go to FILL.
  - Non-head flits offered in IDLE are accepted and dropped.
- FILL: `in_ready`=1. Each accepted flit is written at the write count, which then increments.
  - An accepted tail goes to ROUTE.
  - If the accepted flit is slot DEPTH-1 and not a tail, it is stored as tail, `err_len` is set, and the FSM goes to ROUTE. Remaining flits of that packet arrive in IDLE as non-head flits and are dropped.
  - A head flit arriving in FILL is stored as an ordinary flit; no recovery is attempted.
- ROUTE (exactly 1 cycle, `in_ready`=0): capture `dec_port`, `dec_addr1_rm` and `dec_fwdab_en`, reset the read pointer, go to SEND_A.
- SEND_A: stream flits 0..count-1.
  - `out_port` = LOCAL_PORT if the captured fwdab=1, else the captured port.
  - Header is sent unchanged.
  - On the tail transfer: go to SEND_B if fwdab=1, else IDLE.
- SEND_B: replay all flits with `out_port` = captured port. The head flit's [24:5] is replaced with the captured `addr1_rm`; all other bits are unchanged. On the tail transfer go to IDLE.
- `out_head` is 1 on slot 0 of each pass; `out_tail` is 1 on the last stored slot.
- `in_ready` is 0 in ROUTE, SEND_A and SEND_B: one packet in flight.
- `hdr_*` registers hold their value until the next head is accepted.

## Timing
- Reset (synchronous, mid-packet included): FSM returns to IDLE and buffered flits are discarded.
  - Cleared to 0: count, read pointer, captured route, `hdr_*`, `err_len`.
  - `out_valid`=0, `out_port`=0.
  - `in_ready`=0 while `rst`=1, then 1 on the first cycle after release.
- `out_valid`, `out_data`, `out_port`, `out_head` and `out_tail` are registered/state-derived. Once `out_valid`=1, they are held stable until `out_valid & out_ready`.
- A transfer occurs on any cycle with `valid & ready` on either side. There are no bubbles within a pass when `out_ready`=1.
- Latency: tail accepted at edge T → ROUTE during cycle T+1 → first `out_valid` in cycle T+2.
- Throughput: back-to-back passes have no idle cycle between SEND_A's tail and SEND_B's head. After the final tail, IDLE with `in_ready`=1 starts the next cycle.
- The decoder is combinational from the `hdr_*` registers. Its inputs are stable by ROUTE because `hdr_*` was loaded at least one edge earlier.

## Test plan
- Unicast, 3 flits, `addr0`=5'd9, decoder stub returns port 2, fwdab 0.
  - Out: 3 flits on port 2, head bit-exact.
  - First `out_valid` 2 cycles after tail accept; `in_ready` returns 1 after the tail.
- Absorb-and-forward, 1 flit, `addr1`=20'h00220, stub returns port 1, `addr1_rm`=20'h00200, fwdab 1.
  - First pass: port 4, head [24:5]=20'h00220.
  - Second pass: port 1, head [24:5]=20'h00200.
  - Both passes have `out_head`=`out_tail`=1.
- Backpressure: 4-flit packet with `out_ready` toggling 1,0,0,1,…
  - Data and port are held during stalls; exactly 4 transfers occur, in order.
- Overlength: 6-flit packet, DEPTH=4.
  - `err_len`=1; 4 flits are sent with the tail on slot 3; flits 5–6 are dropped.
  - The next packet is handled normally.
- Reset during SEND_B after 1 flit: `out_valid`=0 the next cycle; a subsequent unicast packet routes correctly.
- Stray body flit in IDLE: accepted and dropped; `out_valid` stays 0.
